// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op codes, ALU control encodings
// and the per-entry record held in the issue FIFO.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;

  typedef enum logic [2:0] {
    ALUC_ADD     = 3'b000,
    ALUC_SUB     = 3'b001,
    ALUC_AND     = 3'b010,
    ALUC_OR      = 3'b011,
    ALUC_XOR     = 3'b100,
    ALUC_NOR     = 3'b101,
    ALUC_ILLEGAL = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    alu_ctrl_e   ctrl;
    logic [4:0]  rd;
    logic        err;
  } entry_t;

  function automatic alu_ctrl_e decode_op(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALUC_ADD;
      OP_SUB:  return ALUC_SUB;
      OP_AND:  return ALUC_AND;
      OP_OR:   return ALUC_OR;
      OP_XOR:  return ALUC_XOR;
      OP_NOR:  return ALUC_NOR;
      default: return ALUC_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count; storage is unreset,
// only pointers and count clear on reset.
module issue_fifo
  import alu_pkg::*;
#(
  parameter type         T     = entry_t,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T           mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes and buffers operations, drives the ALU from
// the FIFO head and registers the ALU result toward writeback.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [31:0]   in_rs1_val,
  input  logic [31:0]   in_rs2_val,
  input  logic [15:0]   in_imm,
  input  logic          in_use_imm,
  input  logic [4:0]    in_rd,
  output logic [31:0]   alu_src1,
  output logic [31:0]   alu_src2,
  output logic [2:0]    alu_control,
  input  logic [31:0]   alu_result,
  input  logic          alu_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic          out_zero,
  output logic [4:0]    out_rd,
  output logic          out_err,
  output logic [CW-1:0] count
);

  entry_t in_entry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  always_comb begin
    in_entry      = '0;
    in_entry.src1 = in_rs1_val;
    in_entry.src2 = in_use_imm ? {{16{in_imm[15]}}, in_imm} : in_rs2_val;
    in_entry.ctrl = decode_op(in_op);
    in_entry.rd   = in_rd;
    in_entry.err  = (in_op > OP_NOR);
  end

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && (!out_valid || out_ready);

  issue_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Stale storage must never reach the ALU, so an empty FIFO forces zeros.
  assign alu_src1    = empty ? '0 : head.src1;
  assign alu_src2    = empty ? '0 : head.src2;
  assign alu_control = empty ? '0 : head.ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_rd     <= '0;
      out_err    <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_zero   <= alu_zero;
      out_rd     <= head.rd;
      out_err    <= head.err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model checked
// every cycle, directed literal scenarios and a randomized phase.
module tb_alu_issue_stage;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [31:0]   in_rs1_val = '0;
  logic [31:0]   in_rs2_val = '0;
  logic [15:0]   in_imm = '0;
  logic          in_use_imm = 1'b0;
  logic [4:0]    in_rd = '0;
  logic [31:0]   alu_src1;
  logic [31:0]   alu_src2;
  logic [2:0]    alu_control;
  logic [31:0]   alu_result;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_result;
  logic          out_zero;
  logic [4:0]    out_rd;
  logic          out_err;
  logic [CW-1:0] count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_rd(out_rd), .out_err(out_err), .count(count)
  );

  // Operation semantics by op code; codes 6..15 produce 0.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for the external combinational ALU.
  assign alu_result = alu_fn({1'b0, alu_control}, alu_src1, alu_src2);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        err;
  } op_t;

  op_t         mq[$];
  logic        mv = 1'b0;
  logic [31:0] mres = '0;
  logic        mzero = 1'b0;
  logic [4:0]  mrd = '0;
  logic        merr = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mv = 1'b0; mres = '0; mzero = 1'b0; mrd = '0; merr = 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      op_t e;
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && (!mv || out_ready);
      e.a     = in_rs1_val;
      e.b     = in_use_imm ? {{16{in_imm[15]}}, in_imm} : in_rs2_val;
      e.ctrl  = (in_op < 4'd6) ? in_op[2:0] : 3'b111;
      e.res   = alu_fn(in_op, e.a, e.b);
      e.rd    = in_rd;
      e.err   = (in_op >= 4'd6);
      if (do_pop) begin
        mv = 1'b1; mres = mq[0].res; mzero = (mq[0].res == 32'd0);
        mrd = mq[0].rd; merr = mq[0].err;
        void'(mq.pop_front());
      end else if (out_ready) begin
        mv = 1'b0;
      end
      if (do_push) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != DEPTH});
    check("count", {30'd0, count}, mq.size());
    check("out_valid", {31'd0, out_valid}, {31'd0, mv});
    check("alu_src1", alu_src1, (mq.size() > 0) ? mq[0].a : 32'd0);
    check("alu_src2", alu_src2, (mq.size() > 0) ? mq[0].b : 32'd0);
    check("alu_control", {29'd0, alu_control}, (mq.size() > 0) ? {29'd0, mq[0].ctrl} : 32'd0);
    if (mv) begin
      check("out_result", out_result, mres);
      check("out_zero", {31'd0, out_zero}, {31'd0, mzero});
      check("out_rd", {27'd0, out_rd}, {27'd0, mrd});
      check("out_err", {31'd0, out_err}, {31'd0, merr});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic use_imm, input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_rs1_val = a; in_rs2_val = b;
    in_imm = imm; in_use_imm = use_imm; in_rd = rd;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, {30'd0, count}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_result"}, out_result, 32'd0);
    check({tag, "_out_flags"}, {25'd0, out_rd, out_zero, out_err}, 32'd0);
    check({tag, "_alu_ports"}, alu_src1 | alu_src2 | {29'd0, alu_control}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    step();

    // SUB 10-10 -> zero result
    drive(4'd1, 32'd10, 32'd10, 16'd0, 1'b0, 5'd3);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("sub_ctrl", {29'd0, alu_control}, 32'd1);
    step();
    @(negedge clk);
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    check("sub_result", out_result, 32'd0);
    check("sub_zero_rd_err", {25'd0, out_rd, out_zero, out_err}, {25'd0, 5'd3, 1'b1, 1'b0});
    step();

    // ADD with sign-extended immediate -1
    drive(4'd0, 32'd5, 32'h1234_5678, 16'hFFFF, 1'b1, 5'd7);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("imm_src2", alu_src2, 32'hFFFF_FFFF);
    step();
    @(negedge clk);
    check("imm_result", out_result, 32'd4);
    check("imm_zero", {31'd0, out_zero}, 32'd0);
    step();

    // Illegal op
    drive(4'd9, 32'd7, 32'd7, 16'd0, 1'b0, 5'd12);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("ill_ctrl", {29'd0, alu_control}, 32'd7);
    step();
    @(negedge clk);
    check("ill_result", out_result, 32'd0);
    check("ill_zero_err", {30'd0, out_zero, out_err}, 32'd3);
    step();

    // Backpressure: three pushes while writeback stalls
    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd2, 16'd0, 1'b0, 5'd1); step();
    drive(4'd3, 32'hF0, 32'h0F, 16'd0, 1'b0, 5'd2); step();
    drive(4'd4, 32'hFF, 32'h0F, 16'd0, 1'b0, 5'd3); step();
    in_valid = 1'b0;
    check("bp_count", {30'd0, count}, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_held_result", out_result, 32'd3);
    step();
    check("bp_still_held", {26'd0, out_rd, out_valid}, {26'd0, 5'd1, 1'b1});
    out_ready = 1'b1;
    step();
    check("bp_drain1", out_result, 32'hFF);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_drain2", out_result, 32'hF0);
    step();
    check("bp_idle", {31'd0, out_valid}, 32'd0);

    // Reset while two entries are queued
    out_ready = 1'b0;
    drive(4'd2, 32'hAA, 32'h0F, 16'd0, 1'b0, 5'd4); step();
    drive(4'd3, 32'h1, 32'h2, 16'd0, 1'b0, 5'd5); step();
    drive(4'd4, 32'h3, 32'h5, 16'd0, 1'b0, 5'd6); step();
    in_valid = 1'b0;
    check("pre_rst_count", {30'd0, count}, 32'd2);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();

    // Back-to-back logical ops
    for (int i = 0; i < 8; i++) begin
      drive(4'($urandom_range(2, 5)), $urandom, $urandom, 16'($urandom), 1'($urandom), 5'(i));
      step();
    end
    check("b2b_count", {30'd0, count}, 32'd1);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive(($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5)),
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
              16'($urandom), 1'($urandom), 5'($urandom));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
